// File: rtl/scalar_mul_ctrl.sv
// Left-to-right double-and-add controller computing R = k*G; every doubling and addition goes to an external point-add unit.
// Optional build macro SMUL_DUMMY_ADD_EN: also issue a discarded add on zero bits once the accumulator is finite.
module scalar_mul_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int K_WIDTH    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [K_WIDTH-1:0]    k,
  input  logic [DATA_WIDTH-1:0] Gx,
  input  logic [DATA_WIDTH-1:0] Gy,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] Rx,
  output logic [DATA_WIDTH-1:0] Ry,
  output logic                  add_in_valid,
  output logic [DATA_WIDTH-1:0] add_Px,
  output logic [DATA_WIDTH-1:0] add_Py,
  output logic [DATA_WIDTH-1:0] add_Qx,
  output logic [DATA_WIDTH-1:0] add_Qy,
  input  logic [DATA_WIDTH-1:0] add_Rx,
  input  logic [DATA_WIDTH-1:0] add_Ry,
  input  logic                  add_out_valid
);

  localparam int IW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_BIT      = 3'd2,
    S_DBL_REQ  = 3'd3,
    S_DBL_WAIT = 3'd4,
    S_ADD_REQ  = 3'd5,
    S_ADD_WAIT = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t                state_r, state_next;
  logic [K_WIDTH-1:0]    k_r, k_next;
  logic [DATA_WIDTH-1:0] gx_r, gx_next, gy_r, gy_next;
  logic [DATA_WIDTH-1:0] acc_x_r, acc_x_next, acc_y_r, acc_y_next;
  logic                  acc_inf_r, acc_inf_next;
  logic [IW-1:0]         idx_r, idx_next;
  logic                  dbl_done_r, dbl_done_next;
  logic                  dummy_r, dummy_next;
  logic                  step_s;
  logic                  busy_next, out_valid_next, add_req_next;
  logic [DATA_WIDTH-1:0] rx_next, ry_next, px_next, py_next, qx_next, qy_next;

  // Next-state, datapath and registered-output values
  always_comb begin
    state_next    = state_r;
    k_next        = k_r;
    gx_next       = gx_r;
    gy_next       = gy_r;
    acc_x_next    = acc_x_r;
    acc_y_next    = acc_y_r;
    acc_inf_next  = acc_inf_r;
    idx_next      = idx_r;
    dbl_done_next = dbl_done_r;
    dummy_next    = dummy_r;
    step_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          k_next        = k;
          gx_next       = Gx;
          gy_next       = Gy;
          acc_x_next    = {DATA_WIDTH{1'b0}};
          acc_y_next    = {DATA_WIDTH{1'b0}};
          acc_inf_next  = 1'b1;
          idx_next      = IW'(K_WIDTH - 1);
          dbl_done_next = 1'b0;
          dummy_next    = 1'b0;
          state_next    = S_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LOAD: state_next = S_BIT;
      S_BIT: begin
        // dbl_done marks the revisit after a doubling, where only the add decision remains
        if (!acc_inf_r && !dbl_done_r) begin
          state_next = S_DBL_REQ;
        end else begin
          dbl_done_next = 1'b0;
          if (k_r[idx_r]) begin
            if (acc_inf_r) begin
              acc_x_next   = gx_r;
              acc_y_next   = gy_r;
              acc_inf_next = (gx_r == {DATA_WIDTH{1'b0}}) && (gy_r == {DATA_WIDTH{1'b0}});
              step_s       = 1'b1;
            end else begin
              dummy_next = 1'b0;
              state_next = S_ADD_REQ;
            end
          end else begin
`ifdef SMUL_DUMMY_ADD_EN
            if (!acc_inf_r) begin
              dummy_next = 1'b1;
              state_next = S_ADD_REQ;
            end else begin
              step_s = 1'b1;
            end
`else
            step_s = 1'b1;
`endif
          end
        end
      end
      S_DBL_REQ: state_next = S_DBL_WAIT;
      S_DBL_WAIT: begin
        if (add_out_valid) begin
          acc_x_next    = add_Rx;
          acc_y_next    = add_Ry;
          acc_inf_next  = (add_Rx == {DATA_WIDTH{1'b0}}) && (add_Ry == {DATA_WIDTH{1'b0}});
          dbl_done_next = 1'b1;
          state_next    = S_BIT;
        end else begin
          state_next = S_DBL_WAIT;
        end
      end
      S_ADD_REQ: state_next = S_ADD_WAIT;
      S_ADD_WAIT: begin
        if (add_out_valid) begin
          if (!dummy_r) begin
            acc_x_next   = add_Rx;
            acc_y_next   = add_Ry;
            acc_inf_next = (add_Rx == {DATA_WIDTH{1'b0}}) && (add_Ry == {DATA_WIDTH{1'b0}});
          end else begin
            acc_inf_next = acc_inf_r;
          end
          step_s = 1'b1;
        end else begin
          state_next = S_ADD_WAIT;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (step_s) begin
      if (idx_r == {IW{1'b0}}) begin
        state_next = S_DONE;
      end else begin
        idx_next   = idx_r - IW'(1);
        state_next = S_BIT;
      end
    end else begin
      idx_next = idx_next;
    end

    busy_next      = (state_next != S_IDLE);
    add_req_next   = (state_next == S_DBL_REQ) || (state_next == S_ADD_REQ);
    out_valid_next = (state_r == S_DONE);
    px_next        = {DATA_WIDTH{1'b0}};
    py_next        = {DATA_WIDTH{1'b0}};
    qx_next        = {DATA_WIDTH{1'b0}};
    qy_next        = {DATA_WIDTH{1'b0}};
    case (state_next)
      S_DBL_REQ, S_DBL_WAIT: begin
        px_next = acc_x_next;
        py_next = acc_y_next;
        qx_next = acc_x_next;
        qy_next = acc_y_next;
      end
      S_ADD_REQ, S_ADD_WAIT: begin
        px_next = acc_x_next;
        py_next = acc_y_next;
        qx_next = gx_next;
        qy_next = gy_next;
      end
      default: begin
        px_next = {DATA_WIDTH{1'b0}};
      end
    endcase
    if (state_r == S_DONE) begin
      rx_next = acc_inf_r ? {DATA_WIDTH{1'b0}} : acc_x_r;
      ry_next = acc_inf_r ? {DATA_WIDTH{1'b0}} : acc_y_r;
    end else begin
      rx_next = Rx;
      ry_next = Ry;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      k_r          <= {K_WIDTH{1'b0}};
      gx_r         <= {DATA_WIDTH{1'b0}};
      gy_r         <= {DATA_WIDTH{1'b0}};
      acc_x_r      <= {DATA_WIDTH{1'b0}};
      acc_y_r      <= {DATA_WIDTH{1'b0}};
      acc_inf_r    <= 1'b1;
      idx_r        <= {IW{1'b0}};
      dbl_done_r   <= 1'b0;
      dummy_r      <= 1'b0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      Rx           <= {DATA_WIDTH{1'b0}};
      Ry           <= {DATA_WIDTH{1'b0}};
      add_in_valid <= 1'b0;
      add_Px       <= {DATA_WIDTH{1'b0}};
      add_Py       <= {DATA_WIDTH{1'b0}};
      add_Qx       <= {DATA_WIDTH{1'b0}};
      add_Qy       <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_next;
      k_r          <= k_next;
      gx_r         <= gx_next;
      gy_r         <= gy_next;
      acc_x_r      <= acc_x_next;
      acc_y_r      <= acc_y_next;
      acc_inf_r    <= acc_inf_next;
      idx_r        <= idx_next;
      dbl_done_r   <= dbl_done_next;
      dummy_r      <= dummy_next;
      busy         <= busy_next;
      out_valid    <= out_valid_next;
      Rx           <= rx_next;
      Ry           <= ry_next;
      add_in_valid <= add_req_next;
      add_Px       <= px_next;
      add_Py       <= py_next;
      add_Qx       <= qx_next;
      add_Qy       <= qy_next;
    end
  end

endmodule
